// File: rtl/bpi_seq_ctrl_if.sv
// bpi_seq_ctrl_if: request/acknowledge and bus-handshake bundle around the BPI command sequencer.
//   master: decoder/FIFO and bus-interface side; drives requests and handshakes, observes strobes.
//   slave : sequencer side; samples requests and handshakes, drives strobes and status.
//   Requests  : WRITE_N, READ_N, OTHER, READ_1, NOOP, ABORT, WORD_CNT, CMD_CYCLES
//   Handshake : RDY, BUSY, LD_DAT, MT
//   Strobes   : LOAD_N, EXECUTE, DECR, NEXT, SEQ_DONE
//   Status    : CYCLE_IDX, WORDS_LEFT, ERR_CODE, OUT_STATE
interface bpi_seq_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 3
);
    logic             WRITE_N;
    logic             READ_N;
    logic             OTHER;
    logic             READ_1;
    logic             NOOP;
    logic             ABORT;
    logic [CNT_W-1:0] WORD_CNT;
    logic [CYC_W-1:0] CMD_CYCLES;
    logic             RDY;
    logic             BUSY;
    logic             LD_DAT;
    logic             MT;
    logic             LOAD_N;
    logic             EXECUTE;
    logic             DECR;
    logic             NEXT;
    logic             SEQ_DONE;
    logic [CYC_W-1:0] CYCLE_IDX;
    logic [CNT_W-1:0] WORDS_LEFT;
    logic [1:0]       ERR_CODE;
    logic [3:0]       OUT_STATE;

    modport master (
        output WRITE_N, READ_N, OTHER, READ_1, NOOP, ABORT, WORD_CNT, CMD_CYCLES,
        output RDY, BUSY, LD_DAT, MT,
        input  LOAD_N, EXECUTE, DECR, NEXT, SEQ_DONE, CYCLE_IDX, WORDS_LEFT, ERR_CODE, OUT_STATE
    );

    modport slave (
        input  WRITE_N, READ_N, OTHER, READ_1, NOOP, ABORT, WORD_CNT, CMD_CYCLES,
        input  RDY, BUSY, LD_DAT, MT,
        output LOAD_N, EXECUTE, DECR, NEXT, SEQ_DONE, CYCLE_IDX, WORDS_LEFT, ERR_CODE, OUT_STATE
    );
endinterface

// File: rtl/bpi_seq_ctrl.sv
// bpi_seq_ctrl: BPI flash command sequencer between the command decoder/FIFO and the bus interface.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : bpi_seq_ctrl_if.slave, carrying requests, bus handshakes, Moore strobes and status
// Block reads/writes are counted down internally from WORD_CNT; OTHER commands run
// CMD_CYCLES bus cycles. A per-state watchdog and an ABORT input both divert to Error,
// which holds ERR_CODE until NOOP acknowledges it.
module bpi_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int CYC_W   = 3,
    parameter int TO_W    = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic          CLK,
    input  logic          RST_N,
    bpi_seq_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_DECR       = 4'd1,
        S_EX_CYCLE   = 4'd2,
        S_EX_RW      = 4'd4,
        S_LOAD_N     = 4'd5,
        S_NEXT       = 4'd6,
        S_SEQ_DONE   = 4'd7,
        S_WAIT4DATA  = 4'd8,
        S_WAIT4RDY   = 4'd9,
        S_WAIT4RDYRW = 4'd11,
        S_ERROR      = 4'd12
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CYC_W-1:0] ncyc_q, ncyc_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             r1_q, r1_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [1:0]       err_q, err_d;
    logic             in_wait;
    logic             exit_ok;
    logic             timed_out;
    logic             abortable;

    always_comb begin
        in_wait   = state_q inside {S_WAIT4RDYRW, S_EX_RW, S_WAIT4DATA, S_WAIT4RDY, S_EX_CYCLE};
        // Exit condition of the current wait state; Ex_RW and Ex_Cycle both leave on BUSY.
        exit_ok   = (state_q == S_WAIT4RDYRW) ? (bus.RDY && (rd_q || (wr_q && !bus.MT))) :
                    (state_q == S_WAIT4RDY)   ? bus.RDY :
                    (state_q == S_WAIT4DATA)  ? bus.LD_DAT : bus.BUSY;
        timed_out = (TIMEOUT != 0) && in_wait && !exit_ok && (wd_q == TO_LAST);
        abortable = !(state_q inside {S_IDLE, S_SEQ_DONE, S_ERROR});
        state_d   = state_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        ncyc_d    = ncyc_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        r1_d      = r1_q;
        err_d     = err_q;
        if (bus.ABORT && abortable) begin
            state_d = S_ERROR;
            err_d   = 2'b10;
        end else if (timed_out) begin
            state_d = S_ERROR;
            err_d   = 2'b01;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.READ_N || bus.WRITE_N) begin
                        state_d = S_LOAD_N;
                        rd_d    = bus.READ_N;
                        wr_d    = bus.WRITE_N && !bus.READ_N;
                        cnt_d   = bus.WORD_CNT;
                    end else if (bus.OTHER) begin
                        // Clearing rd keeps Wait4Data on the single-read exit for OTHER commands.
                        state_d = S_WAIT4RDY;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        ncyc_d  = (bus.CMD_CYCLES == '0) ? CYC_W'(1) : bus.CMD_CYCLES;
                        r1_d    = bus.READ_1;
                        cyc_d   = '0;
                    end
                end
                S_LOAD_N:     state_d = (cnt_q == '0) ? S_SEQ_DONE : S_WAIT4RDYRW;
                S_WAIT4RDYRW: state_d = exit_ok ? S_EX_RW : state_q;
                S_EX_RW:      state_d = !exit_ok ? state_q : rd_q ? S_WAIT4DATA : S_DECR;
                S_WAIT4DATA:  state_d = !exit_ok ? state_q : rd_q ? S_DECR : S_SEQ_DONE;
                S_DECR: begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_NEXT;
                end
                S_NEXT:       state_d = (cnt_q == '0) ? S_SEQ_DONE : S_WAIT4RDYRW;
                S_WAIT4RDY:   state_d = exit_ok ? S_EX_CYCLE : state_q;
                S_EX_CYCLE: begin
                    if (exit_ok) begin
                        if (cyc_q == ncyc_q - CYC_W'(1)) begin
                            state_d = r1_q ? S_WAIT4DATA : S_SEQ_DONE;
                        end else begin
                            cyc_d   = cyc_q + CYC_W'(1);
                            state_d = S_WAIT4RDY;
                        end
                    end
                end
                S_SEQ_DONE:   state_d = bus.NOOP ? S_IDLE : state_q;
                S_ERROR: begin
                    if (bus.NOOP) begin
                        state_d = S_IDLE;
                        err_d   = 2'b00;
                    end
                end
                default:      state_d = S_IDLE;
            endcase
        end
        // Watchdog restarts on every state change and only runs while waiting.
        wd_d = ((state_d != state_q) || !in_wait) ? '0 : wd_q + TO_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cyc_q   <= '0;
            ncyc_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            r1_q    <= 1'b0;
            wd_q    <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            ncyc_q  <= ncyc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            r1_q    <= r1_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign bus.LOAD_N     = (state_q == S_LOAD_N);
    assign bus.EXECUTE    = (state_q == S_EX_RW) || (state_q == S_EX_CYCLE);
    assign bus.DECR       = (state_q == S_DECR);
    assign bus.NEXT       = (state_q == S_NEXT);
    assign bus.SEQ_DONE   = (state_q == S_SEQ_DONE);
    assign bus.CYCLE_IDX  = cyc_q;
    assign bus.WORDS_LEFT = cnt_q;
    assign bus.ERR_CODE   = err_q;
    assign bus.OUT_STATE  = state_q;
endmodule

// File: tb/tb_bpi_seq_ctrl.sv
// tb_bpi_seq_ctrl: directed self-checking bench for bpi_seq_ctrl with a 16-cycle watchdog.
module tb_bpi_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bpi_seq_ctrl_if #(.CNT_W(16), .CYC_W(3)) bus ();

    bpi_seq_ctrl #(.CNT_W(16), .CYC_W(3), .TO_W(20), .TIMEOUT(16)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One word of a block transfer, entered from Wait4RdyRW with its exit condition true.
    task automatic rw_word(input int left, input bit rd);
        tick;
        check("ex_rw_state", 32'(bus.OUT_STATE), 4);
        check("ex_rw_exec", 32'(bus.EXECUTE), 1);
        bus.BUSY = 1'b1;
        tick;
        bus.BUSY = 1'b0;
        check("after_busy", 32'(bus.OUT_STATE), rd ? 8 : 1);
        if (rd) begin
            bus.LD_DAT = 1'b1;
            tick;
            bus.LD_DAT = 1'b0;
            check("after_lddat", 32'(bus.OUT_STATE), 1);
        end
        check("decr_strobe", 32'(bus.DECR), 1);
        check("left_in_decr", 32'(bus.WORDS_LEFT), 32'(left));
        tick;
        check("next_strobe", 32'(bus.NEXT), 1);
        check("left_in_next", 32'(bus.WORDS_LEFT), 32'(left - 1));
        tick;
        check("after_next", 32'(bus.OUT_STATE), (left == 1) ? 7 : 11);
    endtask

    task automatic start_rw(input bit rd, input bit wr, input int n);
        bus.READ_N   = rd;
        bus.WRITE_N  = wr;
        bus.WORD_CNT = 16'(n);
        tick;
        bus.READ_N  = 1'b0;
        bus.WRITE_N = 1'b0;
        check("load_state", 32'(bus.OUT_STATE), 5);
        check("load_strobe", 32'(bus.LOAD_N), 1);
        check("load_left", 32'(bus.WORDS_LEFT), 32'(n));
    endtask

    task automatic ack(input int err);
        bus.NOOP = 1'b1;
        tick;
        bus.NOOP = 1'b0;
        check("ack_idle", 32'(bus.OUT_STATE), 0);
        check("ack_err", 32'(bus.ERR_CODE), 32'(err));
    endtask

    initial begin
        {bus.WRITE_N, bus.READ_N, bus.OTHER, bus.READ_1, bus.NOOP, bus.ABORT} = '0;
        {bus.RDY, bus.BUSY, bus.LD_DAT, bus.MT} = '0;
        bus.WORD_CNT   = '0;
        bus.CMD_CYCLES = '0;
        tick;
        tick;
        check("rst_state", 32'(bus.OUT_STATE), 0);
        check("rst_outs", {6'd0, bus.LOAD_N, bus.EXECUTE, bus.DECR, bus.NEXT, bus.SEQ_DONE,
                           bus.CYCLE_IDX, bus.WORDS_LEFT, bus.ERR_CODE}, 0);
        rst_n = 1'b1;
        tick;
        check("idle_after_rst", 32'(bus.OUT_STATE), 0);

        // Three-word block read.
        bus.RDY = 1'b1;
        start_rw(1'b1, 1'b0, 3);
        tick;
        check("rd_wait_rdyrw", 32'(bus.OUT_STATE), 11);
        check("load_once", 32'(bus.LOAD_N), 0);
        rw_word(3, 1'b1);
        rw_word(2, 1'b1);
        rw_word(1, 1'b1);
        check("rd_seq_done", 32'(bus.SEQ_DONE), 1);
        check("rd_left_zero", 32'(bus.WORDS_LEFT), 0);
        ack(0);

        // Two-word write that stalls while the write FIFO is empty.
        bus.MT = 1'b1;
        start_rw(1'b0, 1'b1, 2);
        tick;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("wr_stall_mt", 32'(bus.OUT_STATE), 11);
        end
        bus.MT = 1'b0;
        rw_word(2, 1'b0);
        rw_word(1, 1'b0);
        check("wr_seq_done", 32'(bus.SEQ_DONE), 1);
        ack(0);

        // Three-cycle OTHER ending in a single data read.
        bus.OTHER      = 1'b1;
        bus.READ_1     = 1'b1;
        bus.CMD_CYCLES = 3'd3;
        tick;
        bus.OTHER = 1'b0;
        check("oth_wait_rdy", 32'(bus.OUT_STATE), 9);
        check("oth_idx0", 32'(bus.CYCLE_IDX), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("oth_ex_cycle", 32'(bus.OUT_STATE), 2);
            check("oth_exec", 32'(bus.EXECUTE), 1);
            check("oth_idx", 32'(bus.CYCLE_IDX), 32'(i));
            bus.BUSY = 1'b1;
            tick;
            bus.BUSY = 1'b0;
            check("oth_after_busy", 32'(bus.OUT_STATE), (i < 2) ? 9 : 8);
            check("oth_exec_low", 32'(bus.EXECUTE), 0);
        end
        bus.LD_DAT = 1'b1;
        tick;
        bus.LD_DAT = 1'b0;
        check("oth_r1_done", 32'(bus.OUT_STATE), 7);
        ack(0);

        // CMD_CYCLES=0 behaves as a single cycle.
        bus.OTHER      = 1'b1;
        bus.READ_1     = 1'b0;
        bus.CMD_CYCLES = 3'd0;
        tick;
        bus.OTHER = 1'b0;
        tick;
        check("oth0_exec", 32'(bus.EXECUTE), 1);
        bus.BUSY = 1'b1;
        tick;
        bus.BUSY = 1'b0;
        check("oth0_done", 32'(bus.OUT_STATE), 7);
        check("oth0_exec_low", 32'(bus.EXECUTE), 0);
        ack(0);

        // Watchdog: RDY stuck low for 16 cycles in Wait4RdyRW.
        bus.RDY = 1'b0;
        start_rw(1'b1, 1'b0, 1);
        tick;
        check("to_enter", 32'(bus.OUT_STATE), 11);
        for (int i = 1; i < 16; i++) begin
            tick;
            check("to_still_wait", 32'(bus.OUT_STATE), 11);
        end
        tick;
        check("to_error", 32'(bus.OUT_STATE), 12);
        check("to_code", 32'(bus.ERR_CODE), 1);
        tick;
        check("to_err_hold", 32'(bus.ERR_CODE), 1);
        ack(0);

        // RDY rising on the 16th cycle beats the watchdog.
        start_rw(1'b1, 1'b0, 1);
        tick;
        for (int i = 1; i < 16; i++) tick;
        check("late_rdy_wait", 32'(bus.OUT_STATE), 11);
        bus.RDY = 1'b1;
        rw_word(1, 1'b1);
        check("late_rdy_err", 32'(bus.ERR_CODE), 0);
        ack(0);

        // ABORT in Ex_RW, asserted together with BUSY.
        start_rw(1'b1, 1'b0, 4);
        tick;
        tick;
        check("ab_ex_rw", 32'(bus.OUT_STATE), 4);
        bus.ABORT = 1'b1;
        bus.BUSY  = 1'b1;
        tick;
        bus.ABORT = 1'b0;
        bus.BUSY  = 1'b0;
        check("ab_error", 32'(bus.OUT_STATE), 12);
        check("ab_code", 32'(bus.ERR_CODE), 2);
        check("ab_no_decr", 32'(bus.DECR), 0);
        check("ab_left", 32'(bus.WORDS_LEFT), 4);
        ack(0);
        bus.ABORT = 1'b1;
        tick;
        bus.ABORT = 1'b0;
        check("ab_idle_ignored", 32'(bus.OUT_STATE), 0);
        check("ab_idle_code", 32'(bus.ERR_CODE), 0);

        // READ_N and WRITE_N together: read wins, so MT does not stall it.
        bus.MT = 1'b1;
        start_rw(1'b1, 1'b1, 1);
        tick;
        rw_word(1, 1'b1);
        bus.MT = 1'b0;
        ack(0);

        // Zero-length read never executes.
        start_rw(1'b1, 1'b0, 0);
        check("z_no_exec_load", 32'(bus.EXECUTE), 0);
        tick;
        check("z_done", 32'(bus.OUT_STATE), 7);
        check("z_no_exec", 32'(bus.EXECUTE), 0);
        ack(0);

        // Asynchronous reset mid-sequence.
        start_rw(1'b1, 1'b0, 2);
        tick;
        tick;
        check("mr_ex_rw", 32'(bus.EXECUTE), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_state", 32'(bus.OUT_STATE), 0);
        check("mr_outs", {6'd0, bus.LOAD_N, bus.EXECUTE, bus.DECR, bus.NEXT, bus.SEQ_DONE,
                          bus.CYCLE_IDX, bus.WORDS_LEFT, bus.ERR_CODE}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("mr_idle", 32'(bus.OUT_STATE), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
